regfile_arbiter: RTL and testbench

Shares the single-ported 8x8 `regfile` between two requesters: requester 0 is the core datapath and requester 1 is the loader/debug port. Each cycle it grants at most one operation, either a dual read or a single write, which matches the regfile's read-or-write-per-cycle rule. It drives the regfile address, data and `r_or_w` ports, and returns registered read data to the granted requester. A bounded lock lets one requester perform an atomic read-modify-write sequence.

---
 rtl/regarb_pkg.sv | 22 ++
 rtl/regarb_mux.sv | 39 +++
 rtl/regfile.sv | 43 ++++
 rtl/regfile_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regarb_pkg.sv
// Shared types and default widths for the regfile arbiter and its command mux.
package regarb_pkg;

    localparam int REGARB_DW = 8;
    localparam int REGARB_AW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                 we;
        logic                 lock;
        logic [REGARB_AW-1:0] ra1;
        logic [REGARB_AW-1:0] ra2;
        logic [REGARB_AW-1:0] wa;
        logic [REGARB_DW-1:0] wd;
    } req_cmd_t;

endpackage

// File: rtl/regarb_mux.sv
// Combinational command mux: puts the granted requester's command on the regfile
// ports, or all zeros (a harmless read) when nobody is granted.
module regarb_mux
    import regarb_pkg::*;
(
    input  logic                 gnt0,
    input  logic                 gnt1,
    input  req_cmd_t             cmd0,
    input  req_cmd_t             cmd1,
    output logic [REGARB_AW-1:0] r_addr1,
    output logic [REGARB_AW-1:0] r_addr2,
    output logic [REGARB_AW-1:0] w_addr,
    output logic [REGARB_DW-1:0] w_data,
    output logic                 r_or_w,
    output logic                 sel_lock
);

    req_cmd_t sel_s;

    // Grants are mutually exclusive, so the priority order here is immaterial.
    always_comb begin
        sel_s = {$bits(req_cmd_t){1'b0}};
        if (gnt0) begin
            sel_s = cmd0;
        end else if (gnt1) begin
            sel_s = cmd1;
        end else begin
            sel_s = {$bits(req_cmd_t){1'b0}};
        end
    end

    assign r_addr1  = sel_s.ra1;
    assign r_addr2  = sel_s.ra2;
    assign w_addr   = sel_s.wa;
    assign w_data   = sel_s.wd;
    assign r_or_w   = sel_s.we;
    assign sel_lock = sel_s.lock;

endmodule

// File: rtl/regfile.sv
// 8x8 register file: two combinational read ports or one write per cycle.
module regfile
    import regarb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REGARB_AW-1:0] r_addr1,
    input  logic [REGARB_AW-1:0] r_addr2,
    input  logic [REGARB_AW-1:0] w_addr,
    input  logic [REGARB_DW-1:0] w_data,
    input  logic                 r_or_w,
    output logic [REGARB_DW-1:0] data1,
    output logic [REGARB_DW-1:0] data2
);

    logic [REGARB_DW-1:0] mem_q [2**REGARB_AW];
    logic [REGARB_DW-1:0] mem_d [2**REGARB_AW];

    // Write port: update one entry when r_or_w is high.
    always_comb begin
        mem_d = mem_q;
        if (r_or_w) begin
            mem_d[w_addr] = w_data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REGARB_AW; i++) begin
                mem_q[i] <= {REGARB_DW{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign data1 = mem_q[r_addr1];
    assign data2 = mem_q[r_addr2];

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter for the single-ported regfile with bounded atomic locking.
// Define REGARB_RR_EN for round-robin in IDLE; otherwise requester 0 has fixed priority.
module regfile_arbiter
    import regarb_pkg::*;
#(
    parameter int DW       = REGARB_DW,
    parameter int AW       = REGARB_AW,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] ra1_0,
    input  logic [AW-1:0] ra2_0,
    input  logic [AW-1:0] ra1_1,
    input  logic [AW-1:0] ra2_1,
    input  logic [AW-1:0] wa0,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1_0,
    output logic [DW-1:0] rdata2_0,
    output logic [DW-1:0] rdata1_1,
    output logic [DW-1:0] rdata2_1,
    output logic [AW-1:0] r_addr1,
    output logic [AW-1:0] r_addr2,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          r_or_w,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2
);

    localparam int             LCW      = $clog2(MAX_LOCK + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);
    localparam logic [LCW-1:0] LOCK_ONE = LCW'(1);

    arb_state_t     state_q, state_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc_s;
    logic           win0_s, win1_s, gnt0_s, gnt1_s, any_gnt_s, sel_lock_s;
    logic           rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DW-1:0]  rdata1_0_q, rdata1_0_d, rdata2_0_q, rdata2_0_d;
    logic [DW-1:0]  rdata1_1_q, rdata1_1_d, rdata2_1_q, rdata2_1_d;
    req_cmd_t       cmd0_s, cmd1_s;
`ifdef REGARB_RR_EN
    logic           rr_q, rr_d;
`endif

    // Pack each requester's command fields for the mux.
    always_comb begin
        cmd0_s = '{we: we0, lock: lock0, ra1: ra1_0, ra2: ra2_0, wa: wa0, wd: wd0};
        cmd1_s = '{we: we1, lock: lock1, ra1: ra1_1, ra2: ra2_1, wa: wa1, wd: wd1};
    end

    // Arbitration: an owner excludes the other side; IDLE resolves contention.
    always_comb begin
        win0_s = 1'b0;
        win1_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
`ifdef REGARB_RR_EN
                    win0_s = ~rr_q;
                    win1_s = rr_q;
`else
                    win0_s = 1'b1;
                    win1_s = 1'b0;
`endif
                end else begin
                    win0_s = req0;
                    win1_s = req1;
                end
            end
            OWN0:    win0_s = req0;
            OWN1:    win1_s = req1;
            default: begin
                win0_s = 1'b0;
                win1_s = 1'b0;
            end
        endcase
    end

    // Gating with rst_n kills the grant (and thus any write) the moment reset asserts.
    assign gnt0_s    = win0_s & rst_n;
    assign gnt1_s    = win1_s & rst_n;
    assign any_gnt_s = gnt0_s | gnt1_s;
    assign gnt0      = gnt0_s;
    assign gnt1      = gnt1_s;

    regarb_mux u_mux (
        .gnt0     (gnt0_s),
        .gnt1     (gnt1_s),
        .cmd0     (cmd0_s),
        .cmd1     (cmd1_s),
        .r_addr1  (r_addr1),
        .r_addr2  (r_addr2),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .r_or_w   (r_or_w),
        .sel_lock (sel_lock_s)
    );

    // Lock FSM: enter on a locked grant, release on an unlocked grant or at MAX_LOCK.
    always_comb begin
        state_d        = state_q;
        lock_cnt_d     = lock_cnt_q;
        lock_cnt_inc_s = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LOCK_ONE;
        case (state_q)
            IDLE: begin
                if (any_gnt_s && sel_lock_s) begin
                    state_d    = gnt1_s ? OWN1 : OWN0;
                    lock_cnt_d = LOCK_ONE;
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = lock_cnt_q;
                end
            end
            OWN0, OWN1: begin
                if (any_gnt_s) begin
                    if (!sel_lock_s || (lock_cnt_inc_s == LOCK_MAX)) begin
                        state_d    = IDLE;
                        lock_cnt_d = {LCW{1'b0}};
                    end else begin
                        lock_cnt_d = lock_cnt_inc_s;
                    end
                end else begin
                    state_d    = state_q;
                    lock_cnt_d = lock_cnt_q;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = {LCW{1'b0}};
            end
        endcase
    end

`ifdef REGARB_RR_EN
    // Any grant that leaves the arbiter in IDLE hands priority to the other side.
    always_comb begin
        if (any_gnt_s && (state_d == IDLE)) begin
            rr_d = gnt0_s;
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin pointer flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Read-data capture at the edge ending a read grant.
    always_comb begin
        rvalid0_d = gnt0_s & ~we0;
        rvalid1_d = gnt1_s & ~we1;
        if (rvalid0_d) begin
            rdata1_0_d = data1;
            rdata2_0_d = data2;
        end else begin
            rdata1_0_d = rdata1_0_q;
            rdata2_0_d = rdata2_0_q;
        end
        if (rvalid1_d) begin
            rdata1_1_d = data1;
            rdata2_1_d = data2;
        end else begin
            rdata1_1_d = rdata1_1_q;
            rdata2_1_d = rdata2_1_q;
        end
    end

    // State, lock counter and read-return registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_cnt_q <= {LCW{1'b0}};
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata1_0_q <= {DW{1'b0}};
            rdata2_0_q <= {DW{1'b0}};
            rdata1_1_q <= {DW{1'b0}};
            rdata2_1_q <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata1_0_q <= rdata1_0_d;
            rdata2_0_q <= rdata2_0_d;
            rdata1_1_q <= rdata1_1_d;
            rdata2_1_q <= rdata2_1_d;
        end
    end

    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata1_0 = rdata1_0_q;
    assign rdata2_0 = rdata2_0_q;
    assign rdata1_1 = rdata1_1_q;
    assign rdata2_1 = rdata2_1_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench: regfile_arbiter plus the real regfile against a behavioural model.
module tb_regfile_arbiter;

    localparam int MAX_LOCK = 4;

    logic       clk, rst_n, rf_rst_n;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [2:0] ra1_0, ra2_0, ra1_1, ra2_1, wa0, wa1;
    logic [7:0] wd0, wd1;
    logic       gnt0, gnt1, rvalid0, rvalid1, r_or_w;
    logic [7:0] rdata1_0, rdata2_0, rdata1_1, rdata2_1, w_data, data1, data2;
    logic [2:0] r_addr1, r_addr2, w_addr;

    regfile_arbiter #(.DW(8), .AW(3), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .ra1_0(ra1_0), .ra2_0(ra2_0), .ra1_1(ra1_1),
        .ra2_1(ra2_1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1), .gnt0(gnt0),
        .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata1_0(rdata1_0),
        .rdata2_0(rdata2_0), .rdata1_1(rdata1_1), .rdata2_1(rdata2_1),
        .r_addr1(r_addr1), .r_addr2(r_addr2), .w_addr(w_addr), .w_data(w_data),
        .r_or_w(r_or_w), .data1(data1), .data2(data2)
    );

    regfile u_rf (
        .clk(clk), .rst_n(rf_rst_n), .r_addr1(r_addr1), .r_addr2(r_addr2),
        .w_addr(w_addr), .w_data(w_data), .r_or_w(r_or_w), .data1(data1), .data2(data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: register contents, owner (0 none, 1 req0, 2 req1), lock count, rr pointer.
    logic [7:0] m_mem [8];
    logic [7:0] m_rd  [4];
    logic       m_rv0, m_rv1, m_rr;
    int         m_own, m_cnt;
    bit         chk_en;
    int         n_cmp, n_bad;

    logic       e_g0, e_g1, e_rw, lk;
    logic [2:0] e_a1, e_a2, e_wa;
    logic [7:0] e_wd;
    int         gi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_cnt = 0; m_rr = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
        for (int i = 0; i < 4; i++) m_rd[i] = 8'd0;
    endtask

    task automatic drv(input int i, input logic r, input logic w, input logic l,
                       input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] wa,
                       input logic [7:0] wd);
        if (i == 0) begin
            req0 = r; we0 = w; lock0 = l; ra1_0 = a1; ra2_0 = a2; wa0 = wa; wd0 = wd;
        end else begin
            req1 = r; we1 = w; lock1 = l; ra1_1 = a1; ra2_1 = a2; wa1 = wa; wd1 = wd;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic arb_reset();
        chk_en = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        drv(1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
    endtask

    // Compare process: every negedge, check outputs against the model, then advance it.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            e_g0 = 1'b0; e_g1 = 1'b0;
            if (m_own == 0) begin
                if (req0 && req1) begin
`ifdef REGARB_RR_EN
                    e_g0 = !m_rr; e_g1 = m_rr;
`else
                    e_g0 = 1'b1;
`endif
                end else begin
                    e_g0 = req0; e_g1 = req1;
                end
            end else if (m_own == 1) e_g0 = req0;
            else e_g1 = req1;

            {e_rw, e_a1, e_a2, e_wa, e_wd} = '0;
            if (e_g0) {e_rw, e_a1, e_a2, e_wa, e_wd} = {we0, ra1_0, ra2_0, wa0, wd0};
            if (e_g1) {e_rw, e_a1, e_a2, e_wa, e_wd} = {we1, ra1_1, ra2_1, wa1, wd1};

            chk("gnt0", gnt0, e_g0);       chk("gnt1", gnt1, e_g1);
            chk("r_or_w", r_or_w, e_rw);   chk("r_addr1", r_addr1, e_a1);
            chk("r_addr2", r_addr2, e_a2); chk("w_addr", w_addr, e_wa);
            chk("w_data", w_data, e_wd);
            chk("rvalid0", rvalid0, m_rv0); chk("rvalid1", rvalid1, m_rv1);
            chk("rdata1_0", rdata1_0, m_rd[0]); chk("rdata2_0", rdata2_0, m_rd[1]);
            chk("rdata1_1", rdata1_1, m_rd[2]); chk("rdata2_1", rdata2_1, m_rd[3]);

            m_rv0 = e_g0 && !we0;
            m_rv1 = e_g1 && !we1;
            if (m_rv0) begin m_rd[0] = m_mem[ra1_0]; m_rd[1] = m_mem[ra2_0]; end
            if (m_rv1) begin m_rd[2] = m_mem[ra1_1]; m_rd[3] = m_mem[ra2_1]; end
            if (e_g0 && we0) m_mem[wa0] = wd0;
            if (e_g1 && we1) m_mem[wa1] = wd1;

            if (e_g0 || e_g1) begin
                gi = e_g1 ? 1 : 0;
                lk = e_g1 ? lock1 : lock0;
                if (m_own == 0) begin
                    if (lk) begin m_own = gi + 1; m_cnt = 1; end
                    else m_rr = (gi == 0);
                end else begin
                    m_cnt++;
                    if (!lk || m_cnt >= MAX_LOCK) begin
                        m_own = 0; m_cnt = 0; m_rr = (gi == 0);
                    end
                end
            end
        end
    end

    logic s0, s1, exp1;

    initial begin
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        rst_n = 1'b0; rf_rst_n = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        drv(1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        for (int i = 0; i < 8; i++) m_mem[i] = 8'd0;
        model_reset();

        // Reset state, with a write request present: nothing may be granted.
        #3;
        drv(0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd5, 8'hAA);
        #1;
        chk("rst_gnt0", gnt0, 1'b0);       chk("rst_r_or_w", r_or_w, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0); chk("rst_rdata1_0", rdata1_0, 8'd0);
        drv(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        #8;
        rst_n = 1'b1; rf_rst_n = 1'b1; chk_en = 1'b1;

        // Write 63 to r2, then read r2/r1.
        step(); drv(0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd2, 8'd63);
        look(); chk("t1_wr_gnt0", gnt0, 1'b1); chk("t1_wr_we", r_or_w, 1'b1);
        step(); drv(0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd1, 3'd0, 8'd0);
        look(); chk("t1_rd_gnt0", gnt0, 1'b1);
        step(); drv(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        look(); chk("t1_rvalid0", rvalid0, 1'b1);
        chk("t1_rdata1_0", rdata1_0, 8'd63); chk("t1_rdata2_0", rdata2_0, 8'd0);
        step(); look(); chk("t1_rvalid0_pulse", rvalid0, 1'b0);

        // Two unlocked contenders for four cycles.
        step(); arb_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            drv(0, 1'b1, 1'b0, 1'b0, 3'(k), 3'(k + 1), 3'd0, 8'd0);
            drv(1, 1'b1, 1'b0, 1'b0, 3'(k + 2), 3'(k + 3), 3'd0, 8'd0);
            look();
`ifdef REGARB_RR_EN
            exp1 = (k % 2 == 1);
`else
            exp1 = 1'b0;
`endif
            chk("t2_gnt1", gnt1, exp1); chk("t2_gnt0", gnt0, !exp1);
            chk("t2_r_addr1", r_addr1, exp1 ? 3'(k + 2) : 3'(k));
        end
        step(); arb_reset();

        // Asynchronous reset during a write of 31 to r4.
        step(); drv(0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd4, 8'd31);
        #1; chk("t5_gnt_pre", gnt0, 1'b1);
        chk_en = 1'b0; rst_n = 1'b0;
        #1; chk("t5_gnt0", gnt0, 1'b0); chk("t5_gnt1", gnt1, 1'b0);
        chk("t5_r_or_w", r_or_w, 1'b0);
        step(); drv(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        rst_n = 1'b1; model_reset(); chk_en = 1'b1;
        step(); drv(0, 1'b1, 1'b0, 1'b0, 3'd4, 3'd4, 3'd0, 8'd0);
        step(); drv(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        look(); chk("t5_rvalid0", rvalid0, 1'b1); chk("t5_r4", rdata1_0, 8'd0);

        // Locked read-modify-write of r4 by requester 1 while requester 0 waits.
        step(); arb_reset();
        step(); drv(1, 1'b1, 1'b0, 1'b1, 3'd4, 3'd4, 3'd0, 8'd0);
        look(); chk("t3_c1_gnt1", gnt1, 1'b1); chk("t3_c1_gnt0", gnt0, 1'b0);
        step(); drv(0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 8'd0);
        drv(1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd4, rdata1_1 + 8'd1);
        look(); chk("t3_c2_gnt1", gnt1, 1'b1); chk("t3_c2_gnt0", gnt0, 1'b0);
        chk("t3_c2_wdata", w_data, 8'd1); chk("t3_c2_rvalid1", rvalid1, 1'b1);
        step(); drv(1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        look(); chk("t3_c3_gnt0", gnt0, 1'b1);
        step(); drv(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);

        // lock0 held for six cycles: forced release after the fourth grant.
        step(); arb_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            drv(0, 1'b1, 1'b0, 1'b1, 3'(k), 3'(7 - k), 3'd0, 8'd0);
            drv(1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd5, 3'd0, 8'd0);
            look();
`ifdef REGARB_RR_EN
            exp1 = (k == 4);
`else
            exp1 = 1'b0;
`endif
            chk("t4_gnt1", gnt1, exp1); chk("t4_gnt0", gnt0, !exp1);
        end

        // Random traffic: each requester holds its command until granted.
        step(); arb_reset();
        s0 = 1'b0; s1 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            s0 = gnt0; s1 = gnt1;
            step();
            if (!req0 || s0)
                drv(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    8'($urandom_range(0, 255)));
            if (!req1 || s1)
                drv(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    8'($urandom_range(0, 255)));
        end
        step();
        drv(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        drv(1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        step(); step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
